// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient-load path: default sizes, derived widths
// and the streamer FSM encoding.
package fir_pkg;

    localparam int NTAPS_DEF  = 7;
    localparam int COEF_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } fir_state_e;

    // Wide enough that NTAPS full-scale coefficients never overflow the sum.
    function automatic int cksum_w(input int ntaps, input int coef_w);
        return coef_w + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Host-writable coefficient register array with a snapshot copy taken at stream launch
// and an indexed read of the snapshot.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int ADDR_W = $clog2(NTAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [COEF_W-1:0] data_i,
    input  logic              snap_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [COEF_W-1:0] rd_data_o,
    output logic [COEF_W-1:0] wt0_o
);

    logic [COEF_W-1:0] bank_q [NTAPS];
    logic [COEF_W-1:0] snap_q [NTAPS];

    // Addresses at or beyond NTAPS match no entry, so those writes fall away.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                bank_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                if (we_i && (addr_i == ADDR_W'(i))) begin
                    bank_q[i] <= data_i;
                end
                if (snap_i) begin
                    snap_q[i] <= (we_i && (addr_i == ADDR_W'(i))) ? data_i : bank_q[i];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        if ({1'b0, rd_idx_i} < (ADDR_W + 1)'(NTAPS)) begin
            rd_data_o = snap_q[rd_idx_i];
        end
    end

    // Tap 0 as it will appear in the snapshot, used to present the first beat at launch.
    assign wt0_o = (we_i && (addr_i == '0)) ? data_i : bank_q[0];

endmodule

// File: rtl/fir_coef_streamer.sv
// Streams a snapshot of the host coefficient bank one tap per beat with valid/ready flow.
// Optional running checksum output enabled by defining FIR_COEF_CKSUM_EN.
module fir_coef_streamer
    import fir_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int ADDR_W = $clog2(NTAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [COEF_W-1:0] host_data,
    input  logic              start,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_val,
    output logic              writeen,
    output logic              tlast,
    output logic              busy,
    output logic              done,
`ifdef FIR_COEF_CKSUM_EN
    output logic [COEF_W+$clog2(NTAPS)-1:0] cksum,
`endif
    output fir_state_e        dbg_state_o
);

    // Handshake: a beat transfers on a rising edge where writeen && coef_ready; while
    // writeen is high and coef_ready low, coef_val/tlast/writeen hold unchanged.

    fir_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [COEF_W-1:0] coef_val_q, coef_val_d;
    logic              writeen_q, writeen_d;
    logic              tlast_q, tlast_d;
    logic              snap;
    logic [ADDR_W-1:0] nxt_idx;
    logic [COEF_W-1:0] rd_data;
    logic [COEF_W-1:0] wt0;
    logic              beat_acc;

    assign nxt_idx  = ADDR_W'(idx_q + 1'b1);
    assign beat_acc = (state_q == S_STREAM) && writeen_q && coef_ready;

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .COEF_W(COEF_W),
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we_i     (host_we),
        .addr_i   (host_addr),
        .data_i   (host_data),
        .snap_i   (snap),
        .rd_idx_i (nxt_idx),
        .rd_data_o(rd_data),
        .wt0_o    (wt0)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            coef_val_q <= '0;
            writeen_q  <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            coef_val_q <= coef_val_d;
            writeen_q  <= writeen_d;
            tlast_q    <= tlast_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        coef_val_d = coef_val_q;
        writeen_d  = writeen_q;
        tlast_d    = tlast_q;
        snap       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap       = 1'b1;
                    state_d    = S_STREAM;
                    idx_d      = '0;
                    coef_val_d = wt0;
                    writeen_d  = 1'b1;
                    tlast_d    = (NTAPS == 1);
                end
            end
            S_STREAM: begin
                if (beat_acc) begin
                    if (idx_q == ADDR_W'(NTAPS - 1)) begin
                        state_d    = S_DONE;
                        idx_d      = '0;
                        coef_val_d = '0;
                        writeen_d  = 1'b0;
                        tlast_d    = 1'b0;
                    end else begin
                        idx_d      = nxt_idx;
                        coef_val_d = rd_data;
                        tlast_d    = (nxt_idx == ADDR_W'(NTAPS - 1));
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FIR_COEF_CKSUM_EN
    localparam int CKSUM_W = cksum_w(NTAPS, COEF_W);
    logic [CKSUM_W-1:0] cksum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cksum_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            cksum_q <= '0;
        end else if (beat_acc) begin
            cksum_q <= cksum_q + CKSUM_W'(coef_val_q);
        end
    end

    assign cksum = cksum_q;
`endif

    assign coef_val    = coef_val_q;
    assign writeen     = writeen_q;
    assign tlast       = tlast_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule
